wishbone_interconnect_nport: RTL
================================

Name: wishbone_interconnect_nport

Overview:
- Parametrised N-slave Wishbone classic interconnect. One master, NUM_SLAVES slaves.
- Decodes the slave index from the top address byte and registers the request toward the selected slave.
- Returns ack/data, or an error for unmapped addresses (and optionally for timeouts).
- Sits between the host bridge master and the peripheral slaves, replacing fixed two-port interconnects.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..16)
SEL_MSB, 31, MSB of slave-select field in m_adr_i
SEL_LSB, 24, LSB of slave-select field; slave sees address with bits [SEL_MSB:SEL_LSB] zeroed
INT_MASK, {NUM_SLAVES{1'b1}}, per-slave interrupt enable for m_int_o
TIMEOUT_CYCLES, 255, max BUSY cycles before error (only with WB_IC_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
m_we_i  in  1  master write enable
m_cyc_i  in  1  master cycle
m_stb_i  in  1  master strobe
m_adr_i  in  32  master address
m_dat_i  in  32  master write data
m_dat_o  out  32  read data (registered)
m_ack_o  out  1  transfer ack, one-cycle pulse
m_err_o  out  1  transfer error, one-cycle pulse
m_int_o  out  1  registered OR of (s_int_i & INT_MASK)
m_int_vec_o  out  NUM_SLAVES  registered raw s_int_i
s_we_o  out  NUM_SLAVES  per-slave write enable
s_cyc_o  out  NUM_SLAVES  per-slave cycle (one-hot or zero)
s_stb_o  out  NUM_SLAVES  per-slave strobe (one-hot or zero)
s_adr_o  out  32*NUM_SLAVES  per-slave address, slice i = [32*i+31:32*i]
s_dat_o  out  32*NUM_SLAVES  per-slave write data
s_dat_i  in  32*NUM_SLAVES  per-slave read data
s_ack_i  in  NUM_SLAVES  per-slave ack
s_int_i  in  NUM_SLAVES  per-slave interrupt

Behaviour:
Reset:
- On rst low, all outputs are 0; state is IDLE; sel_q, data/address latches and the timeout counter are 0.

States:
- IDLE
  - On m_cyc_i & m_stb_i, latch idx = m_adr_i[SEL_MSB:SEL_LSB], plus m_adr_i (select field zeroed), m_dat_i and m_we_i.
  - If idx < NUM_SLAVES, go to BUSY.
  - Otherwise go to ERR.
- BUSY
  - Assert s_cyc_o[idx] and s_stb_o[idx], with s_we_o/s_adr_o/s_dat_o slice idx driven from the latches. All other slices are 0.
  - On s_ack_i[idx]: capture s_dat_i slice idx into m_dat_o, drop all slave strobes/cycles, go to RESP.
- RESP
  - m_ack_o = 1 for exactly one cycle, then return to IDLE.
- ERR
  - m_err_o = 1 for exactly one cycle, m_dat_o = 0, then return to IDLE. No slave is strobed.

Latency:
- Request sampled at edge 0 → slave strobe visible after edge 0.
- Slave ack sampled at edge k → m_ack_o high after edge k+1.
- Minimum 3 cycles request-to-ack.

Abort and hand-off:
- m_cyc_i or m_stb_i low while in BUSY: abort immediately (next edge). Slave signals drop, state goes to IDLE, no ack or err.
- In RESP/ERR the pulse completes regardless of master inputs.
- A new request is accepted only from IDLE, so back-to-back transfers have one idle cycle between the ack pulse and the next slave strobe.

Stray acks:
- s_ack_i on non-selected slaves, or any ack in IDLE/RESP/ERR, is ignored.

Data path:
- m_dat_o holds its last captured value until the next RESP/ERR.

Interrupts:
- m_int_vec_o <= s_int_i every cycle.
- m_int_o <= |(s_int_i & INT_MASK). One cycle latency; independent of the transfer state.

Optional Feature:
WB_IC_TIMEOUT_EN
- Defined:
  - A counter clears on entering BUSY and increments each BUSY cycle.
  - When count == TIMEOUT_CYCLES-1 without an ack, the next state is ERR: slave strobes drop and m_err_o pulses once.
  - An ack in the same cycle as expiry wins (goes to RESP).
- Undefined: no counter; BUSY waits indefinitely for ack or master abort.

Decomposition:
- Package wb_ic_pkg holds:
  - the state enum (IDLE, BUSY, RESP, ERR)
  - ADR_W=32 and DAT_W=32
  - SEL_W derived from SEL_MSB-SEL_LSB+1
- One sub-module, wb_ic_addr_decode (combinational): idx in → one-hot select + valid flag. It is reused by future multi-master arbiters.

Test Plan:
- Write to slave 2 (adr 0x0200_0010, dat 0xDEADBEEF); slave acks 2 cycles after its strobe → s_stb_o=4'b0100, s_adr_o[2]=0x0000_0010, s_dat_o[2]=0xDEADBEEF; one m_ack_o pulse; other slices 0.
- Read from slave 0, s_dat_i[0]=0x12345678 → m_dat_o=0x12345678 coincident with the m_ack_o pulse.
- Unmapped address 0x0700_0000 with NUM_SLAVES=4 → m_err_o pulses 1 cycle, no s_stb_o asserted, m_ack_o stays 0.
- Master drops m_stb_i while slave 1 has not acked → s_stb_o/s_cyc_o go 0 next cycle, no ack/err. A later slave-1 ack is ignored.
- s_int_i=4'b1010 with INT_MASK=4'b0010 → one cycle later m_int_vec_o=4'b1010, m_int_o=1. With s_int_i=4'b1000 → m_int_o=0.
- WB_IC_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks → m_err_o pulses after 8 BUSY cycles and strobes drop. Assert rst low mid-BUSY → all outputs 0 immediately.

Source files
------------

// File: rtl/wb_ic_pkg.sv
// Shared types and widths for the N-port Wishbone classic interconnect.
package wb_ic_pkg;

    localparam int unsigned ADR_W       = 32;
    localparam int unsigned DAT_W       = 32;
    localparam int unsigned SEL_MSB_DEF = 31;
    localparam int unsigned SEL_LSB_DEF = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    function automatic int unsigned sel_width(input int unsigned msb, input int unsigned lsb);
        return msb - lsb + 1;
    endfunction

    localparam int unsigned SEL_W = sel_width(SEL_MSB_DEF, SEL_LSB_DEF);

endpackage

// File: rtl/wb_ic_addr_decode.sv
// Combinational slave decoder: select-field index to one-hot slave select plus mapped flag.
module wb_ic_addr_decode
    import wb_ic_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned IDX_W      = SEL_W
) (
    input  logic [IDX_W-1:0]      idx,
    output logic [NUM_SLAVES-1:0] onehot_c,
    output logic                  valid_c
);

    assign valid_c = (32'(idx) < NUM_SLAVES);

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_sel
        assign onehot_c[g] = (32'(idx) == 32'(g));
    end

endmodule

// File: rtl/wishbone_interconnect_nport.sv
// One-master, NUM_SLAVES-slave Wishbone classic interconnect with registered request path.
// Optional bus timeout is enabled by defining WB_IC_TIMEOUT_EN.
module wishbone_interconnect_nport
    import wb_ic_pkg::*;
#(
    parameter int unsigned           NUM_SLAVES     = 4,
    parameter int unsigned           SEL_MSB        = SEL_MSB_DEF,
    parameter int unsigned           SEL_LSB        = SEL_LSB_DEF,
    parameter logic [NUM_SLAVES-1:0] INT_MASK       = {NUM_SLAVES{1'b1}},
    parameter int unsigned           TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        m_we_i,
    input  logic                        m_cyc_i,
    input  logic                        m_stb_i,
    input  logic [ADR_W-1:0]            m_adr_i,
    input  logic [DAT_W-1:0]            m_dat_i,
    output logic [DAT_W-1:0]            m_dat_o,
    output logic                        m_ack_o,
    output logic                        m_err_o,
    output logic                        m_int_o,
    output logic [NUM_SLAVES-1:0]       m_int_vec_o,
    output logic [NUM_SLAVES-1:0]       s_we_o,
    output logic [NUM_SLAVES-1:0]       s_cyc_o,
    output logic [NUM_SLAVES-1:0]       s_stb_o,
    output logic [ADR_W*NUM_SLAVES-1:0] s_adr_o,
    output logic [DAT_W*NUM_SLAVES-1:0] s_dat_o,
    input  logic [DAT_W*NUM_SLAVES-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    input  logic [NUM_SLAVES-1:0]       s_int_i
);

    localparam int unsigned     IDX_W    = sel_width(SEL_MSB, SEL_LSB);
    localparam logic [ADR_W-1:0] SEL_MASK = ADR_W'(((64'd1 << IDX_W) - 64'd1) << SEL_LSB);

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [ADR_W-1:0]        adr_q, adr_d;
    logic [DAT_W-1:0]        dat_q, dat_d;
    logic                    we_q, we_d;
    logic [DAT_W-1:0]        rdat_d;
    logic                    ack_d, err_d, drive_d;

    logic [NUM_SLAVES-1:0]       dec_onehot;
    logic                        dec_valid;
    logic                        ack_hit;
    logic [DAT_W-1:0]            rdat_sel;
    logic [DAT_W*NUM_SLAVES-1:0] rdat_masked;
    logic [NUM_SLAVES-1:0]       s_cyc_d, s_we_d;
    logic [ADR_W*NUM_SLAVES-1:0] s_adr_d;
    logic [DAT_W*NUM_SLAVES-1:0] s_dat_d;

`ifdef WB_IC_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]            cnt_q, cnt_d;
`endif

    wb_ic_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W)
    ) u_decode (
        .idx      (m_adr_i[SEL_MSB:SEL_LSB]),
        .onehot_c (dec_onehot),
        .valid_c  (dec_valid)
    );

    // Only the selected slave's ack and read data are visible to the FSM.
    assign ack_hit = |(s_ack_i & sel_q);

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slice
        assign rdat_masked[DAT_W*g +: DAT_W] = s_dat_i[DAT_W*g +: DAT_W] & {DAT_W{sel_q[g]}};
        assign s_cyc_d[g]                    = drive_d & sel_d[g];
        assign s_we_d[g]                     = drive_d & sel_d[g] & we_d;
        assign s_adr_d[ADR_W*g +: ADR_W]     = s_cyc_d[g] ? adr_d : '0;
        assign s_dat_d[DAT_W*g +: DAT_W]     = s_cyc_d[g] ? dat_d : '0;
    end

    always_comb begin
        rdat_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            rdat_sel = rdat_sel | rdat_masked[DAT_W*i +: DAT_W];
        end
    end

    // Next-state and next-output logic; registered outputs follow the next state.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        rdat_d  = m_dat_o;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        drive_d = 1'b0;
`ifdef WB_IC_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Skip the cycle where the master still sees the previous ack/err.
                if (m_cyc_i && m_stb_i && !m_ack_o && !m_err_o) begin
                    sel_d = dec_onehot;
                    adr_d = m_adr_i & ~SEL_MASK;
                    dat_d = m_dat_i;
                    we_d  = m_we_i;
                    if (dec_valid) begin
                        state_d = BUSY;
                        drive_d = 1'b1;
`ifdef WB_IC_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            BUSY: begin
                if (!(m_cyc_i && m_stb_i)) begin
                    state_d = IDLE;
                end else if (ack_hit) begin
                    state_d = RESP;
                    rdat_d  = rdat_sel;
                end
`ifdef WB_IC_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end
`endif
                else begin
                    drive_d = 1'b1;
`ifdef WB_IC_TIMEOUT_EN
                    cnt_d   = cnt_q + CNT_W'(1);
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
                ack_d   = 1'b1;
            end
            ERR: begin
                state_d = IDLE;
                err_d   = 1'b1;
                rdat_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            m_dat_o     <= '0;
            m_ack_o     <= 1'b0;
            m_err_o     <= 1'b0;
            m_int_o     <= 1'b0;
            m_int_vec_o <= '0;
            s_we_o      <= '0;
            s_cyc_o     <= '0;
            s_stb_o     <= '0;
            s_adr_o     <= '0;
            s_dat_o     <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            m_dat_o     <= rdat_d;
            m_ack_o     <= ack_d;
            m_err_o     <= err_d;
            m_int_o     <= |(s_int_i & INT_MASK);
            m_int_vec_o <= s_int_i;
            s_we_o      <= s_we_d;
            s_cyc_o     <= s_cyc_d;
            s_stb_o     <= s_cyc_d;
            s_adr_o     <= s_adr_d;
            s_dat_o     <= s_dat_d;
        end
    end

`ifdef WB_IC_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule
